// File: rtl/sop_seq_ctrl.sv
// Sequential 4-term sum-of-products engine: one shared multiplier and one
// accumulator walk the captured terms, then the sum is held until accepted.
module sop_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*WIDTH-1:0]   d_in,
  input  logic [4*WIDTH-1:0]   c_in,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 out_valid,
  output logic [2*WIDTH+1:0]   result,
  output logic [15:0]          op_count
);

  localparam int PROD_W = 2 * WIDTH;
  localparam int ACC_W  = 2 * WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;

  logic [4*WIDTH-1:0] d_reg;
  logic [4*WIDTH-1:0] c_reg;
  logic [1:0]         idx;
  logic [ACC_W-1:0]   acc;

  logic [WIDTH-1:0]   d_sel;
  logic [WIDTH-1:0]   c_sel;
  logic [PROD_W-1:0]  prod;
  logic [ACC_W-1:0]   acc_sum;

  logic               capture;
  logic               mac_step;
  logic               accept;

  // Shared datapath: select the current term pair, multiply, accumulate.
  // Two guard bits on the accumulator cover four worst-case products.
  assign d_sel   = d_reg[int'(idx)*WIDTH +: WIDTH];
  assign c_sel   = c_reg[int'(idx)*WIDTH +: WIDTH];
  assign prod    = PROD_W'(d_sel) * PROD_W'(c_sel);
  assign acc_sum = acc + ACC_W'(prod);

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    mac_step   = 1'b0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = MAC;
        end
      end
      MAC: begin
        mac_step = 1'b1;
        if (idx == 2'd3) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          accept     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // busy and out_valid are registered from the next state, so they change on
  // the same edge as the state and never see start combinationally.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      op_count  <= '0;
      acc       <= '0;
      idx       <= '0;
      d_reg     <= '0;
      c_reg     <= '0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != IDLE);
      out_valid <= (state_next == DONE);

      if (capture) begin
        d_reg <= d_in;
        c_reg <= c_in;
        acc   <= '0;
        idx   <= '0;
      end

      if (mac_step) begin
        acc <= acc_sum;
        idx <= idx + 2'd1;
        // The last term lands straight in result so it is valid with out_valid.
        if (idx == 2'd3) begin
          result <= acc_sum;
        end
      end

      if (accept) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sop_seq_ctrl.sv
// Self-checking bench for sop_seq_ctrl: transaction-level reference model,
// per-cycle output comparison, directed scenarios and a randomized phase.
module tb_sop_seq_ctrl;

  localparam int WIDTH = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [4*WIDTH-1:0]   d_in;
  logic [4*WIDTH-1:0]   c_in;
  logic                 out_ready;
  logic                 busy;
  logic                 out_valid;
  logic [2*WIDTH+1:0]   result;
  logic [15:0]          op_count;

  int n_checks = 0;
  int n_fail   = 0;

  sop_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .d_in      (d_in),
    .c_in      (c_in),
    .out_ready (out_ready),
    .busy      (busy),
    .out_valid (out_valid),
    .result    (result),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  function automatic int sop(input logic [15:0] d, input logic [15:0] c);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      s += int'(d[4*i +: 4]) * int'(c[4*i +: 4]);
    end
    return s;
  endfunction

  // Spread a number 0..255 over four 2-bit terms, one per 4-bit slice.
  function automatic logic [15:0] pack2(input int v);
    logic [15:0] p = '0;
    for (int i = 0; i < 4; i++) begin
      p[4*i +: 4] = 4'((v >> (2*i)) & 3);
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is either absent, counting its four
  // accumulation cycles, or waiting for acceptance with a known sum.
  bit          model_on = 1'b0;
  bit          m_active = 1'b0;
  bit          m_valid  = 1'b0;
  int          m_age    = 0;
  int          m_sum    = 0;
  int          m_result = 0;
  logic [15:0] m_count  = '0;

  always @(posedge clk) begin
    if (rst) begin
      model_on <= 1'b1;
      m_active <= 1'b0;
      m_valid  <= 1'b0;
      m_age    <= 0;
      m_result <= 0;
      m_count  <= '0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_age    <= 0;
        m_sum    <= sop(d_in, c_in);
      end
    end else if (!m_valid) begin
      m_age <= m_age + 1;
      if (m_age == 3) begin
        m_valid  <= 1'b1;
        m_result <= m_sum;
      end
    end else if (out_ready) begin
      m_valid  <= 1'b0;
      m_active <= 1'b0;
      m_count  <= m_count + 16'd1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check("busy_model",      32'(busy),      32'(m_active));
      check("out_valid_model", 32'(out_valid), 32'(m_valid));
      check("result_model",    32'(result),    32'(m_result));
      check("op_count_model",  32'(op_count),  32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat;
    logic [15:0] d_first;
    logic [15:0] c_first;

    rst = 1'b1; start = 1'b0; out_ready = 1'b0; d_in = '0; c_in = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_busy",      32'(busy),      32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result",    32'(result),    32'd0);
    check("reset_op_count",  32'(op_count),  32'd0);

    // Basic operation with consumer always ready.
    d_in = {4'd4, 4'd3, 4'd2, 4'd1};
    c_in = {4'd8, 4'd7, 4'd6, 4'd5};
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0; d_in = 16'($urandom); c_in = 16'($urandom);
    check("basic_busy", 32'(busy), 32'd1);
    wait_valid(lat);
    check("basic_latency", 32'(lat), 32'd4);
    check("basic_result", 32'(result), 32'd70);
    tick();
    check("basic_busy_after", 32'(busy), 32'd0);
    check("basic_op_count", 32'(op_count), 32'd1);

    // Maximum operands, consumer stalls for ten cycles.
    d_in = 16'hFFFF; c_in = 16'hFFFF; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    wait_valid(lat);
    check("max_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("max_hold_result", 32'(result), 32'd900);
      check("max_hold_valid",  32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    tick();
    check("max_valid_drop", 32'(out_valid), 32'd0);
    check("max_op_count", 32'(op_count), 32'd2);

    // start held high and operands churning during the operation.
    d_first = 16'($urandom); c_first = 16'($urandom);
    d_in = d_first; c_in = c_first; start = 1'b1;
    tick();
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      d_in = 16'($urandom); c_in = 16'($urandom);
      tick();
      if (out_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("churn_latency", 32'(lat), 32'd4);
    check("churn_result", 32'(result), 32'(sop(d_first, c_first)));
    tick();
    check("churn_accept_idle", 32'(busy), 32'd0);
    check("churn_one_count", 32'(op_count), 32'd3);
    tick();
    start = 1'b0;
    check("churn_recapture", 32'(busy), 32'd1);
    wait_valid(lat);
    check("churn2_latency", 32'(lat), 32'd4);
    tick();
    check("churn2_op_count", 32'(op_count), 32'd4);

    // Reset during the second accumulation cycle abandons the operation.
    d_in = 16'hFFFF; c_in = 16'h1111; start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_result",    32'(result),    32'd0);
    check("abort_op_count",  32'(op_count),  32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_valid", 32'(out_valid), 32'd0);
    end
    d_in = 16'h2222; c_in = 16'h3333; start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(lat);
    check("after_abort_latency", 32'(lat), 32'd4);
    check("after_abort_result", 32'(result), 32'd24);
    tick();
    check("after_abort_count", 32'(op_count), 32'd1);

    // start and out_ready together in DONE: handshake only, no capture.
    d_in = 16'h1234; c_in = 16'h4321; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    wait_valid(lat);
    check("both_latency", 32'(lat), 32'd4);
    start = 1'b1; out_ready = 1'b1; d_in = 16'h0F0F; c_in = 16'h0303;
    tick();
    check("both_valid_drop", 32'(out_valid), 32'd0);
    check("both_no_capture", 32'(busy), 32'd0);
    check("both_count", 32'(op_count), 32'd2);
    tick();
    start = 1'b0;
    check("both_next_start", 32'(busy), 32'd1);
    wait_valid(lat);
    check("both_next_latency", 32'(lat), 32'd4);
    check("both_next_result", 32'(result), 32'(sop(16'h0F0F, 16'h0303)));
    tick();

    // Sweep every 2-bit combination of the four data terms, back to back.
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 256; i++) begin
      d_in = pack2(i); c_in = pack2((i * 37 + 11) & 255); start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid(lat);
      check("sweep_latency", 32'(lat), 32'd4);
      check("sweep_result", 32'(result), 32'(sop(pack2(i), pack2((i * 37 + 11) & 255))));
      tick();
    end
    check("sweep_op_count", 32'(op_count), 32'd256);

    // Randomized traffic with occasional resets; the model checks each cycle.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      start     = ($urandom_range(0, 2) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      d_in      = 16'($urandom);
      c_in      = 16'($urandom);
      tick();
    end
    rst = 1'b0; start = 1'b0; out_ready = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
